// File: rtl/bip_control.sv
// ---------------------------------------------------------------------------
// bip_control
// Multi-cycle control unit for the BIP accumulator processor. Owns the
// program counter, the instruction register and a FETCH/DECODE/EXEC/HALT
// sequencer, and drives the datapath strobes for the extended instruction
// set (load/store, arithmetic, logic, conditional and unconditional branch).
//
// Ports
//   i_clock        rising-edge clock
//   i_reset        synchronous, active-high reset
//   i_enable       run enable, sampled only in FETCH
//   i_instruction  program-memory read data (one-cycle synchronous memory)
//   i_acc_zero     accumulator == 0, sampled in the last EXEC cycle of BEQ/BNE
//   o_pc           program-memory address
//   o_operand      operand field of the instruction register
//   o_SelA         accumulator input mux: 00 RAM, 01 operand, 10 ALU, 11 none
//   o_SelB         ALU B operand: 0 RAM data, 1 immediate
//   o_Op           ALU op: 000 add, 001 sub, 010 and, 011 or, 100 xor
//   o_WrAcc        accumulator write strobe
//   o_WrRam        data-RAM write strobe
//   o_RdRam        data-RAM read strobe
//   o_halted       high while in HALT
//   o_illegal      sticky flag, an undefined opcode was executed
//   o_instr_count  retired-instruction counter, saturating
// ---------------------------------------------------------------------------
module bip_control #(
   parameter int OPCODE      = 5,
   parameter int OPERAND     = 11,
   parameter int PC_WIDTH    = 11,
   parameter int RAM_LATENCY = 0,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                      i_clock,
   input  logic                      i_reset,
   input  logic                      i_enable,
   input  logic [OPCODE+OPERAND-1:0] i_instruction,
   input  logic                      i_acc_zero,
   output logic [PC_WIDTH-1:0]       o_pc,
   output logic [OPERAND-1:0]        o_operand,
   output logic [1:0]                o_SelA,
   output logic                      o_SelB,
   output logic [2:0]                o_Op,
   output logic                      o_WrAcc,
   output logic                      o_WrRam,
   output logic                      o_RdRam,
   output logic                      o_halted,
   output logic                      o_illegal,
   output logic [CNT_WIDTH-1:0]      o_instr_count
);

   localparam int IW = OPCODE + OPERAND;

   localparam logic [OPCODE-1:0] OP_HLT  = OPCODE'(0);
   localparam logic [OPCODE-1:0] OP_STO  = OPCODE'(1);
   localparam logic [OPCODE-1:0] OP_LD   = OPCODE'(2);
   localparam logic [OPCODE-1:0] OP_LDI  = OPCODE'(3);
   localparam logic [OPCODE-1:0] OP_ADD  = OPCODE'(4);
   localparam logic [OPCODE-1:0] OP_ADDI = OPCODE'(5);
   localparam logic [OPCODE-1:0] OP_SUB  = OPCODE'(6);
   localparam logic [OPCODE-1:0] OP_SUBI = OPCODE'(7);
   localparam logic [OPCODE-1:0] OP_AND  = OPCODE'(8);
   localparam logic [OPCODE-1:0] OP_ANDI = OPCODE'(9);
   localparam logic [OPCODE-1:0] OP_OR   = OPCODE'(10);
   localparam logic [OPCODE-1:0] OP_ORI  = OPCODE'(11);
   localparam logic [OPCODE-1:0] OP_XOR  = OPCODE'(12);
   localparam logic [OPCODE-1:0] OP_XORI = OPCODE'(13);
   localparam logic [OPCODE-1:0] OP_BEQ  = OPCODE'(14);
   localparam logic [OPCODE-1:0] OP_BNE  = OPCODE'(15);
   localparam logic [OPCODE-1:0] OP_JMP  = OPCODE'(16);

   localparam logic [1:0] SELA_RAM  = 2'b00;
   localparam logic [1:0] SELA_OPD  = 2'b01;
   localparam logic [1:0] SELA_ALU  = 2'b10;
   localparam logic [1:0] SELA_NONE = 2'b11;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;

   // Wait-counter value reached in the final EXEC cycle of a RAM read.
   localparam logic [1:0] WAIT_LAST = 2'(RAM_LATENCY);

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_DECODE = 2'd1,
      S_EXEC   = 2'd2,
      S_HALT   = 2'd3
   } state_t;

   state_t                state, state_nx;
   logic [PC_WIDTH-1:0]   pc;
   logic [IW-1:0]         ir;
   logic [1:0]            wcnt;
   logic [CNT_WIDTH-1:0]  cnt;
   logic                  illegal;

   logic [OPCODE-1:0]     opc;
   logic                  is_legal;
   logic                  is_hlt;
   logic                  is_rd;
   logic                  br_taken;
   logic                  exec_last;

   assign opc = ir[IW-1:OPERAND];

   // Instruction classification from the instruction register.
   always_comb begin
      is_legal = 1'b1;
      is_rd    = 1'b0;
      br_taken = 1'b0;
      case (opc)
         OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: is_rd = 1'b1;
         OP_BEQ:  br_taken = i_acc_zero;
         OP_BNE:  br_taken = ~i_acc_zero;
         OP_JMP:  br_taken = 1'b1;
         OP_HLT, OP_STO, OP_LDI, OP_ADDI, OP_SUBI,
         OP_ANDI, OP_ORI, OP_XORI: is_legal = 1'b1;
         default: is_legal = 1'b0;
      endcase
   end

   assign is_hlt = (opc == OP_HLT);

   // RAM-reading ops stretch EXEC until the wait counter reaches the
   // configured latency; everything else executes in a single cycle.
   assign exec_last = (state == S_EXEC) && (!is_rd || (wcnt == WAIT_LAST));

   // ---------------- state register ----------------
   always_ff @(posedge i_clock) begin
      if (i_reset) state <= S_FETCH;
      else         state <= state_nx;
   end

   // ---------------- next state ----------------
   always_comb begin
      state_nx = state;
      case (state)
         S_FETCH:  if (i_enable) state_nx = S_DECODE;
         S_DECODE: state_nx = S_EXEC;
         S_EXEC: begin
            if (exec_last) begin
               if (is_hlt || !is_legal) state_nx = S_HALT;
               else                     state_nx = S_FETCH;
            end
         end
         S_HALT:   state_nx = S_HALT;
         default:  state_nx = S_FETCH;
      endcase
   end

   // ---------------- outputs ----------------
   always_comb begin
      o_SelA  = SELA_NONE;
      o_SelB  = 1'b0;
      o_Op    = ALU_ADD;
      o_WrAcc = 1'b0;
      o_WrRam = 1'b0;
      o_RdRam = 1'b0;
      if (state == S_EXEC) begin
         case (opc)
            OP_STO:  o_WrRam = 1'b1;
            OP_LD: begin
               o_SelA  = SELA_RAM;
               o_RdRam = 1'b1;
               o_WrAcc = exec_last;
            end
            OP_LDI: begin
               o_SelA  = SELA_OPD;
               o_SelB  = 1'b1;
               o_WrAcc = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
               o_SelA  = SELA_ALU;
               o_RdRam = 1'b1;
               o_WrAcc = exec_last;
            end
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI: begin
               o_SelA  = SELA_ALU;
               o_SelB  = 1'b1;
               o_WrAcc = 1'b1;
            end
            default: o_SelA = SELA_NONE;
         endcase
         case (opc)
            OP_SUB, OP_SUBI: o_Op = ALU_SUB;
            OP_AND, OP_ANDI: o_Op = ALU_AND;
            OP_OR,  OP_ORI:  o_Op = ALU_OR;
            OP_XOR, OP_XORI: o_Op = ALU_XOR;
            default:         o_Op = ALU_ADD;
         endcase
      end
   end

   assign o_halted      = (state == S_HALT);
   assign o_pc          = pc;
   assign o_operand     = ir[OPERAND-1:0];
   assign o_illegal     = illegal;
   assign o_instr_count = cnt;

   // ---------------- PC, IR, wait counter, status ----------------
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         pc      <= '0;
         ir      <= '0;
         wcnt    <= '0;
         cnt     <= '0;
         illegal <= 1'b0;
      end else begin
         if (state == S_DECODE) ir <= i_instruction;

         // Counter idles at zero so every EXEC starts a fresh wait.
         if ((state == S_EXEC) && !exec_last) wcnt <= wcnt + 2'd1;
         else                                 wcnt <= '0;

         if (exec_last) begin
            if (!is_legal) begin
               illegal <= 1'b1;
            end else if (!is_hlt) begin
               if (br_taken) pc <= ir[PC_WIDTH-1:0];
               else          pc <= pc + 1'b1;
               if (cnt != '1) cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule
